// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, slice mux codes,
// FSM state encoding and default width / counter width.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_MULT = 3'b111;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_SUM = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode -> slice control decode.
// Ports: op in; ainvert, binvert, less_xor, opsel, cin, b_inv_sel out.
import alu_seq_pkg::*;

module alu_ctrl_decode (
    input  logic [2:0] op,
    output logic       ainvert,
    output logic       binvert,
    output logic       less_xor,
    output logic [1:0] opsel,
    output logic       cin,
    output logic       b_inv_sel
);

    always_comb begin
        ainvert   = 1'b0;
        binvert   = 1'b0;
        less_xor  = 1'b0;
        opsel     = SEL_AND;
        cin       = 1'b0;
        b_inv_sel = 1'b0;
        unique case (op)
            OP_AND: opsel = SEL_AND;
            OP_OR:  opsel = SEL_OR;
            OP_ADD: opsel = SEL_SUM;
            OP_XOR: begin
                opsel    = SEL_XOR;
                less_xor = 1'b1;
            end
            // The slice adder ignores the invert lines, so
            // subtraction inverts b here and injects carry-in.
            OP_SUB, OP_SLT: begin
                opsel     = SEL_SUM;
                cin       = 1'b1;
                b_inv_sel = 1'b1;
            end
            OP_NOR: begin
                ainvert = 1'b1;
                binvert = 1'b1;
            end
            OP_MULT: opsel = SEL_SUM;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator for the bit-slice ALU array: start/done handshake, single
// ops issue once, MULT runs a WIDTH-cycle shift-add loop on the ALU adder.
// Ports: clk, reset, start, op, a, b in; busy, done, result, carry, zero
// out; alu_a/b, alu_cin, alu_ainvert/binvert/less_xor, alu_opsel out;
// alu_result, alu_cout in.
import alu_seq_pkg::*;

module alu_sequencer #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_ainvert,
    output logic             alu_binvert,
    output logic             alu_less_xor,
    output logic [1:0]       alu_opsel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_n;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;   // operand a; multiplicand m in MUL
    logic [WIDTH-1:0] b_r;   // operand b; multiplier q in MUL
    logic [WIDTH-1:0] p;
    logic [CW-1:0]    cnt;

    logic             d_ainv, d_binv, d_lx, d_cin, d_binv_sel;
    logic [1:0]       d_opsel;

    logic             last, lt, addsub;
    logic [WIDTH-1:0] exec_res, mul_res;

    alu_ctrl_decode u_dec (
        .op        (op_r),
        .ainvert   (d_ainv),
        .binvert   (d_binv),
        .less_xor  (d_lx),
        .opsel     (d_opsel),
        .cin       (d_cin),
        .b_inv_sel (d_binv_sel)
    );

    assign last   = (cnt == CW'(WIDTH - 1));
    assign addsub = (op_r == OP_ADD) || (op_r == OP_SUB);

    // Signs differ: a<b iff a is negative; else sign of a-b decides.
    assign lt = (a_r[WIDTH-1] != b_r[WIDTH-1]) ? a_r[WIDTH-1]
                                               : alu_result[WIDTH-1];

    assign exec_res = (op_r == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt}
                                       : alu_result;

    // Final product includes the add made in the last MUL cycle.
    assign mul_res = b_r[0] ? alu_result : p;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            p      <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                        p    <= '0;
                        cnt  <= '0;
                    end
                end
                EXEC: begin
                    result <= exec_res;
                    carry  <= addsub & alu_cout;
                    zero   <= (exec_res == '0);
                end
                MUL: begin
                    if (b_r[0]) p <= alu_result;
                    a_r <= a_r << 1;
                    b_r <= b_r >> 1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result <= mul_res;
                        carry  <= 1'b0;
                        zero   <= (mul_res == '0);
                    end
                end
                DONE: ;
            endcase
        end
    end

    always_comb begin
        state_n      = state;
        busy         = (state != IDLE);
        done         = (state == DONE);
        alu_a        = '0;
        alu_b        = '0;
        alu_cin      = 1'b0;
        alu_ainvert  = 1'b0;
        alu_binvert  = 1'b0;
        alu_less_xor = 1'b0;
        alu_opsel    = SEL_AND;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (op == OP_MULT) ? MUL : EXEC;
            end
            EXEC: begin
                state_n      = DONE;
                alu_a        = a_r;
                alu_b        = d_binv_sel ? ~b_r : b_r;
                alu_cin      = d_cin;
                alu_ainvert  = d_ainv;
                alu_binvert  = d_binv;
                alu_less_xor = d_lx;
                alu_opsel    = d_opsel;
            end
            MUL: begin
                if (last) state_n = DONE;
                alu_a     = p;
                alu_b     = a_r;
                alu_opsel = SEL_SUM;
            end
            DONE: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a word-level slice array
// model and an arithmetic reference for every opcode.
module tb_alu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, carry, zero;
    logic [W-1:0] result, alu_a, alu_b, alu_result;
    logic         alu_cin, alu_ainvert, alu_binvert;
    logic         alu_less_xor, alu_cout;
    logic [1:0]   alu_opsel;

    int n_assert = 0;
    int n_fail   = 0;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_ainvert  (alu_ainvert),
        .alu_binvert  (alu_binvert),
        .alu_less_xor (alu_less_xor),
        .alu_opsel    (alu_opsel),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout)
    );

    always #5 clk = ~clk;

    // Slice array at word level: adder uses raw operands.
    logic [W-1:0] ai, bi;
    logic [W:0]   sum;
    always_comb begin
        ai  = alu_ainvert ? ~alu_a : alu_a;
        bi  = alu_binvert ? ~alu_b : alu_b;
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
        case (alu_opsel)
            2'b00:   alu_result = ai & bi;
            2'b01:   alu_result = ai | bi;
            2'b10:   alu_result = sum[W-1:0];
            default: alu_result = alu_less_xor ? (alu_a ^ alu_b) : '0;
        endcase
        alu_cout = sum[W];
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_op(input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic c);
        logic [63:0] prod;
        c = 1'b0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: {c, r} = {1'b0, x} + {1'b0, y};
            3'd3: r = x ^ y;
            3'd4: begin r = x - y; c = (x >= y); end
            3'd5: r = ($signed(x) < $signed(y)) ? 1 : 0;
            3'd6: r = ~(x | y);
            default: begin
                prod = {32'd0, x} * {32'd0, y};
                r = prod[W-1:0];
            end
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output logic [W-1:0] got);
        logic [W-1:0] er;
        logic         ec, lx;
        int           n;
        ref_op(o, x, y, er, ec);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        n = 1; lx = 1'b0;
        while (!done && n < 100) begin
            lx |= alu_less_xor;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", 64'(n), (o == 3'd7) ? 64'd33 : 64'd2);
        check("done", 64'(done), 64'd1);
        check("busy_in_done", 64'(busy), 64'd1);
        check("result", 64'(result), 64'(er));
        check("carry", 64'(carry), 64'(ec));
        check("zero", 64'(zero), 64'(er == 0));
        check("less_xor", 64'(lx), 64'(o == 3'd3));
        got = result;
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("result_hold", 64'(result), 64'(er));
    endtask

    initial begin
        logic [W-1:0] r;
        logic         seen;
        int           n;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", {62'd0, carry, zero}, 64'd0);
        check("rst_alu", {alu_a, alu_b}, 64'd0);
        check("rst_ctl", {58'd0, alu_cin, alu_ainvert, alu_binvert,
              alu_less_xor, alu_opsel}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(3'd2, 32'hFFFF_FFFF, 32'd1, r);
        check("add_wrap", 64'(r), 64'd0);
        do_op(3'd4, 32'd5, 32'd7, r);
        check("sub_neg", 64'(r), 64'hFFFF_FFFE);
        do_op(3'd5, 32'h8000_0000, 32'd1, r);
        check("slt_neg", 64'(r), 64'd1);
        do_op(3'd5, 32'd1, 32'h8000_0000, r);
        check("slt_pos", 64'(r), 64'd0);
        do_op(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, r);
        check("xor", 64'(r), 64'h0FF0_0FF0);
        do_op(3'd6, 32'd0, 32'h0000_FFFF, r);
        check("nor", 64'(r), 64'hFFFF_0000);
        do_op(3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, r);
        do_op(3'd1, 32'hFF00_0000, 32'h0000_00FF, r);
        do_op(3'd7, 32'd1234, 32'd5678, r);
        check("mult", 64'(r), 64'd7006652);
        do_op(3'd7, 32'hFFFF_FFFF, 32'd2, r);
        check("mult_wrap", 64'(r), 64'hFFFF_FFFE);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]   o;
            logic [W-1:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = (i % 5 == 0) ? x : $urandom;
            do_op(o, x, y, r);
        end

        // Starts during busy and during DONE must be ignored.
        op = 3'd7; a = 32'd3; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (4) begin @(posedge clk); n++; @(negedge clk); end
        op = 3'd2; a = 32'd100; b = 32'd1; start = 1'b1;
        @(posedge clk); n++;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        check("ign_latency", 64'(n), 64'd33);
        check("ign_result", 64'(result), 64'd21);
        op = 3'd2; a = 32'd100; b = 32'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("ign_done_busy", 64'(busy), 64'd0);
        check("ign_done_done", 64'(done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("ign_idle_busy", 64'(busy), 64'd0);
        check("ign_keep", 64'(result), 64'd21);

        // Reset during MULT aborts with no done.
        op = 3'd7; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mul_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_alu", {alu_a, alu_b}, 64'd0);
        check("abort_ctl", {58'd0, alu_cin, alu_ainvert, alu_binvert,
              alu_less_xor, alu_opsel}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            seen |= done | busy;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        do_op(3'd2, 32'd40, 32'd2, r);
        check("post_abort", 64'(r), 64'd42);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
